// File: rtl/ebus_dev_pi.sv
// EBUS device with priority-interrupt (PI) support. It decodes CONO/CONI/DATAO/DATAI/PI_SERVE.
// Latency: demand sampled at edge N in IDLE -> xfer high from edge N+3; writes land on that same edge.
// Backpressure: initiator-paced; xfer holds while demand stays high, and release waits for demand to drop.
module ebus_dev_pi #(
  parameter logic [2:0]  CTL_NUM = 3'd4,
  parameter logic [17:0] VECTOR  = 18'o000140
) (
  input  logic        clk_ebus_h,
  input  logic        mr_reset_h,
  input  logic        ebus_demand_e_h,
  input  logic [2:0]  ebus_f_e_h,
  input  logic [0:7]  ebus_cs_e_h,
  input  logic [0:35] ebus_d_in_e_h,
  output logic [0:35] ebus_d_out_e_h,
  output logic        ebus_d_oe_h,
  output logic        ebus_xfer_e_h,
  output logic [1:7]  ebus_pi_e_h,
  input  logic        dev_req_h,
  output logic [0:35] dev_data_h
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, REL} state_t;

  localparam logic [2:0] F_CONO  = 3'b000;
  localparam logic [2:0] F_CONI  = 3'b001;
  localparam logic [2:0] F_DATAO = 3'b010;
  localparam logic [2:0] F_DATAI = 3'b011;
  localparam logic [2:0] F_PI    = 3'b100;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  f_q, f_d;
  logic [2:0]  pia_q, pia_d;
  logic        pend_q, pend_d;
  logic [0:35] data_q, data_d;
  logic        wait_low_q, wait_low_d;

  logic        sel;
  logic        pend_set;
  logic        pend_clr;

  // Only our own select line matters; the rest of the one-hot bus is intentionally ignored.
  logic        unused_cs;
  assign unused_cs = ^ebus_cs_e_h;

  // Selection: PI_SERVE matches on pending interrupt and PIA level on d[3:5], others on chip select.
  always_comb begin
    sel = 1'b0;
    if (ebus_f_e_h == F_PI) begin
      sel = pend_q && (pia_q != 3'd0) && (ebus_d_in_e_h[3:5] == pia_q);
    end else begin
      sel = ebus_cs_e_h[CTL_NUM];
    end
  end

  // Next-state, register writes and pending set/clear; a set always wins over a clear.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f_d        = f_q;
    pia_d      = pia_q;
    data_d     = data_q;
    pend_set   = dev_req_h;
    pend_clr   = 1'b0;
    // Once demand has been seen low after reset, the device may accept transfers again.
    wait_low_d = wait_low_q && ebus_demand_e_h;
    case (state_q)
      IDLE: begin
        if (ebus_demand_e_h && !wait_low_q && (ebus_f_e_h <= F_PI) && sel) begin
          state_d = SETUP;
          cnt_d   = 2'd0;
          f_d     = ebus_f_e_h;
        end
      end
      SETUP: begin
        if (!ebus_demand_e_h) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd2) begin
          state_d = XFER;
          if (f_q == F_CONO) begin
            pia_d = ebus_d_in_e_h[33:35];
            if (ebus_d_in_e_h[32]) pend_clr = 1'b1;
            if (ebus_d_in_e_h[31]) pend_set = 1'b1;
          end
          if (f_q == F_DATAO) begin
            data_d = ebus_d_in_e_h;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      XFER: begin
        if (!ebus_demand_e_h) begin
          state_d = REL;
          if (f_q == F_PI) pend_clr = 1'b1;
        end
      end
      REL: begin
        if (!ebus_demand_e_h) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_d = pend_q;
    if (pend_clr) pend_d = 1'b0;
    if (pend_set) pend_d = 1'b1;
  end

  // State and register flops; reset parks everything and arms the wait-for-demand-low guard.
  always_ff @(posedge clk_ebus_h or posedge mr_reset_h) begin
    if (mr_reset_h) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      f_q        <= 3'd0;
      pia_q      <= 3'd0;
      pend_q     <= 1'b0;
      data_q     <= '0;
      wait_low_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f_q        <= f_d;
      pia_q      <= pia_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      wait_low_q <= wait_low_d;
    end
  end

  assign ebus_xfer_e_h = (state_q == XFER);
  assign ebus_d_oe_h   = (state_q == XFER);
  assign dev_data_h    = data_q;

  // Read-data mux; the bus is driven to zero whenever output enable is low.
  always_comb begin
    ebus_d_out_e_h = '0;
    if (state_q == XFER) begin
      case (f_q)
        F_CONI: begin
          ebus_d_out_e_h[33:35] = pia_q;
          ebus_d_out_e_h[32]    = pend_q;
        end
        F_DATAI: ebus_d_out_e_h        = data_q;
        F_PI:    ebus_d_out_e_h[18:35] = VECTOR;
        default: ebus_d_out_e_h        = '0;
      endcase
    end
  end

  // Drive the request line selected by PIA; PIA=0 masks the request while keeping it pending.
  always_comb begin
    ebus_pi_e_h = '0;
    for (int i = 1; i <= 7; i++) begin
      if (pia_q == 3'(i)) ebus_pi_e_h[i] = pend_q;
    end
  end

endmodule

// File: tb/tb_ebus_dev_pi.sv
module tb_ebus_dev_pi;

  logic        clk;
  logic        rst;
  logic        demand;
  logic [2:0]  f;
  logic [0:7]  cs;
  logic [0:35] din;
  logic [0:35] dout;
  logic        oe;
  logic        xfer;
  logic [1:7]  pi;
  logic        dev_req;
  logic [0:35] dev_data;

  int checks = 0;
  int errors = 0;

  localparam logic [0:7] CS4 = 8'b00001000;
  localparam logic [0:7] CS3 = 8'b00010000;

  ebus_dev_pi dut (
    .clk_ebus_h      (clk),
    .mr_reset_h      (rst),
    .ebus_demand_e_h (demand),
    .ebus_f_e_h      (f),
    .ebus_cs_e_h     (cs),
    .ebus_d_in_e_h   (din),
    .ebus_d_out_e_h  (dout),
    .ebus_d_oe_h     (oe),
    .ebus_xfer_e_h   (xfer),
    .ebus_pi_e_h     (pi),
    .dev_req_h       (dev_req),
    .dev_data_h      (dev_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one bus transfer: reports whether xfer appeared, at which edge, and what was driven.
  task automatic bus_op(input logic [2:0] fn, input logic [0:7] c, input logic [0:35] d,
                        output bit seen, output int lat, output logic [0:35] rd, output logic rd_oe);
    f = fn; cs = c; din = d; demand = 1'b1;
    seen = 1'b0; lat = 0; rd = '0; rd_oe = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      tick();
      if (xfer) begin
        seen = 1'b1; lat = k; rd = dout; rd_oe = oe;
      end
    end
    demand = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_req();
    dev_req = 1'b1;
    tick();
    dev_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; demand = 1'b0; f = 3'd0; cs = '0; din = '0; dev_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({xfer, oe, dout, pi, dev_data} !== 81'd0) begin
      errors++;
      $display("FAIL reset_outputs got xfer=%b oe=%b dout=%o pi=%b data=%o, want all zero",
               xfer, oe, dout, pi, dev_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({xfer, oe, dout, pi, dev_data} !== 81'd0) begin
      errors++;
      $display("FAIL reset_release got xfer=%b oe=%b dout=%o pi=%b data=%o, want all zero",
               xfer, oe, dout, pi, dev_data);
    end
  endtask

  task automatic test_cono_pi();
    bit seen; int lat; logic [0:35] rd; logic rd_oe;
    bus_op(3'b000, CS4, 36'o000000000005, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || lat != 4) begin
      errors++;
      $display("FAIL cono_latency got seen=%0d lat=%0d, want seen=1 lat=4", seen, lat);
    end
    checks++;
    if (pi !== 7'b0000000) begin
      errors++;
      $display("FAIL cono_no_pending got pi=%b, want 0000000", pi);
    end
    bus_op(3'b001, CS4, 36'o0, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || rd !== 36'o000000000005 || rd_oe !== 1'b1) begin
      errors++;
      $display("FAIL coni_idle got seen=%0d dout=%o oe=%b, want 1 000000000005 1", seen, rd, rd_oe);
    end
    pulse_req();
    checks++;
    if (pi !== 7'b0000100) begin
      errors++;
      $display("FAIL pi_request got pi=%b, want 0000100", pi);
    end
    bus_op(3'b001, CS4, 36'o0, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || rd !== 36'o000000000015) begin
      errors++;
      $display("FAIL coni_pending got seen=%0d dout=%o, want 1 000000000015", seen, rd);
    end
  endtask

  task automatic test_pi_serve();
    bit seen; int lat; logic [0:35] rd; logic rd_oe;
    bus_op(3'b100, 8'b0, 36'o050000000000, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || lat != 4 || rd !== 36'o000000000140 || rd_oe !== 1'b1) begin
      errors++;
      $display("FAIL pi_serve_vector got seen=%0d lat=%0d dout=%o oe=%b, want 1 4 000000000140 1",
               seen, lat, rd, rd_oe);
    end
    checks++;
    if (pi !== 7'b0000000 || dout !== 36'o0) begin
      errors++;
      $display("FAIL pi_serve_clear got pi=%b dout=%o, want 0000000 0", pi, dout);
    end
    pulse_req();
    bus_op(3'b100, 8'b0, 36'o040000000000, seen, lat, rd, rd_oe);
    checks++;
    if (seen || pi !== 7'b0000100) begin
      errors++;
      $display("FAIL pi_serve_wrong_level got seen=%0d pi=%b, want 0 0000100", seen, pi);
    end
  endtask

  task automatic test_data();
    bit seen; int lat; logic [0:35] rd; logic rd_oe;
    bus_op(3'b010, CS4, 36'o123456701234, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || dev_data !== 36'o123456701234) begin
      errors++;
      $display("FAIL datao got seen=%0d data=%o, want 1 123456701234", seen, dev_data);
    end
    bus_op(3'b011, CS4, 36'o0, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || lat != 4 || rd !== 36'o123456701234) begin
      errors++;
      $display("FAIL datai got seen=%0d lat=%0d dout=%o, want 1 4 123456701234", seen, lat, rd);
    end
    bus_op(3'b010, CS3, 36'o777777777777, seen, lat, rd, rd_oe);
    checks++;
    if (seen || dev_data !== 36'o123456701234) begin
      errors++;
      $display("FAIL datao_wrong_cs got seen=%0d data=%o, want 0 123456701234", seen, dev_data);
    end
    bus_op(3'b101, CS4, 36'o0, seen, lat, rd, rd_oe);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bad_function got seen=%0d, want 0", seen);
    end
  endtask

  task automatic test_setup_abort();
    bit hit = 1'b0;
    f = 3'b010; cs = CS4; din = 36'o111111111111; demand = 1'b1;
    tick();
    hit = hit | xfer;
    tick();
    hit = hit | xfer;
    demand = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      hit = hit | xfer;
    end
    checks++;
    if (hit || dev_data !== 36'o123456701234) begin
      errors++;
      $display("FAIL setup_abort got xfer_seen=%0d data=%o, want 0 123456701234", hit, dev_data);
    end
  endtask

  task automatic test_set_wins();
    bit seen = 1'b0;
    f = 3'b100; cs = '0; din = 36'o050000000000; demand = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = xfer;
    end
    demand = 1'b0; dev_req = 1'b1;
    tick();
    dev_req = 1'b0;
    checks++;
    if (!seen || xfer !== 1'b0 || pi !== 7'b0000100) begin
      errors++;
      $display("FAIL set_wins got seen=%0d xfer=%b pi=%b, want 1 0 0000100", seen, xfer, pi);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0; bit hit = 1'b0; int lat; logic [0:35] rd; logic rd_oe;
    f = 3'b011; cs = CS4; din = 36'o0; demand = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = xfer;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!seen || {xfer, oe, dout, pi, dev_data} !== 81'd0) begin
      errors++;
      $display("FAIL reset_mid got seen=%0d xfer=%b oe=%b dout=%o pi=%b data=%o, want 1 and all zero",
               seen, xfer, oe, dout, pi, dev_data);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      hit = hit | xfer;
    end
    checks++;
    if (hit) begin
      errors++;
      $display("FAIL reset_held_demand got xfer_seen=%0d, want 0", hit);
    end
    demand = 1'b0;
    tick();
    bus_op(3'b011, CS4, 36'o0, seen, lat, rd, rd_oe);
    checks++;
    if (!seen || lat != 4 || rd !== 36'o0) begin
      errors++;
      $display("FAIL reset_rearm got seen=%0d lat=%0d dout=%o, want 1 4 0", seen, lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_cono_pi();
    test_pi_serve();
    test_data();
    test_setup_abort();
    test_set_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
